// File: rtl/blit_seq_pkg.sv
// rtl/blit_seq_pkg.sv - shared state encoding and constants for the blit loop sequencer
package blit_seq_pkg;

   localparam int unsigned DEF_IW   = 10;
   localparam int unsigned DEF_OW   = 8;
   localparam int unsigned TERM_CNT = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RELOAD = 2'd2,
      ST_DONE   = 2'd3
   } t_blit_seq_state;

endpackage

// File: rtl/dn_cnt_ld.sv
// rtl/dn_cnt_ld.sv - loadable down counter built from toggle slices with ripple borrow
module dn_cnt_ld
   import blit_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         LD,
   input  logic [W-1:0] LD_VAL,
   input  logic         DEC,
   output logic [W-1:0] CNT,
   output logic         IS_ONE
);

   logic [W-1:0] borrow;
   logic [W-1:0] cnt_dec;

   // Bit 0 borrows on the decrement enable; each higher slice borrows while all lower bits are zero.
   assign borrow[0] = DEC;

   for (genvar i = 1; i < W; i++) begin : g_borrow
      assign borrow[i] = borrow[i-1] & ~CNT[i-1];
   end

   // A slice toggles whenever its borrow-in is high, giving a modulo-2^W decrement.
   assign cnt_dec = CNT ^ borrow;

   assign IS_ONE = (CNT == W'(TERM_CNT));

   // Load wins over decrement; with DEC low cnt_dec equals CNT, so the count holds.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         CNT <= '0;
      end else if (LD) begin
         CNT <= LD_VAL;
      end else begin
         CNT <= cnt_dec;
      end
   end

endmodule

// File: rtl/blit_loop_sequencer.sv
// rtl/blit_loop_sequencer.sv - two-level element/line step sequencer for the blitter
module blit_loop_sequencer
   import blit_seq_pkg::*;
#(
   parameter int IW = DEF_IW,
   parameter int OW = DEF_OW
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          START,
   input  logic          ABORT,
   input  logic [IW-1:0] INNER_LEN,
   input  logic [OW-1:0] OUTER_LEN,
   input  logic          STEP,
   output logic [IW-1:0] INNER_CNT,
   output logic [OW-1:0] OUTER_CNT,
   output logic          INNER_LAST,
   output logic          OUTER_STEP,
   output logic          STALL,
   output logic          BUSY,
   output logic          DONE
);

   t_blit_seq_state state;

   logic          in_ld;
   logic [IW-1:0] in_ld_val;
   logic          in_dec;
   logic          in_one;
   logic          out_ld;
   logic [OW-1:0] out_ld_val;
   logic          out_dec;
   logic          out_one;

   // Counter load/decrement requests; ABORT freezes both counts.
   always_comb begin
      in_ld      = 1'b0;
      in_ld_val  = INNER_LEN;
      in_dec     = 1'b0;
      out_ld     = 1'b0;
      out_ld_val = OUTER_LEN;
      out_dec    = 1'b0;
      if (!ABORT) begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  in_ld  = 1'b1;
                  out_ld = 1'b1;
               end
            end
            ST_RUN: begin
               if (STEP) begin
                  if (!in_one) begin
                     in_dec = 1'b1;
                  end else begin
                     in_ld     = 1'b1;
                     in_ld_val = '0;
                     if (out_one) begin
                        out_ld     = 1'b1;
                        out_ld_val = '0;
                     end
                  end
               end
            end
            ST_RELOAD: begin
               // INNER_LEN is re-sampled so the CPU may change it between lines.
               in_ld   = 1'b1;
               out_dec = 1'b1;
            end
            default: ;
         endcase
      end
   end

   dn_cnt_ld #(.W(IW)) u_inner (
      .CLK    (CLK),
      .RESET  (RESET),
      .LD     (in_ld),
      .LD_VAL (in_ld_val),
      .DEC    (in_dec),
      .CNT    (INNER_CNT),
      .IS_ONE (in_one)
   );

   dn_cnt_ld #(.W(OW)) u_outer (
      .CLK    (CLK),
      .RESET  (RESET),
      .LD     (out_ld),
      .LD_VAL (out_ld_val),
      .DEC    (out_dec),
      .CNT    (OUTER_CNT),
      .IS_ONE (out_one)
   );

   assign INNER_LAST = (state == ST_RUN) && in_one;

   // Sequencer FSM with registered status outputs that track the next state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         STALL      <= 1'b0;
         OUTER_STEP <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else if (ABORT) begin
         state      <= ST_IDLE;
         STALL      <= 1'b0;
         OUTER_STEP <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         STALL      <= 1'b0;
         OUTER_STEP <= 1'b0;
         DONE       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  state <= ST_RUN;
                  BUSY  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (STEP && in_one) begin
                  if (out_one) begin
                     state <= ST_DONE;
                     DONE  <= 1'b1;
                  end else begin
                     state      <= ST_RELOAD;
                     STALL      <= 1'b1;
                     OUTER_STEP <= 1'b1;
                  end
               end
            end
            ST_RELOAD: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule
